// File: rtl/stack_op_sequencer_if.sv
// Request and stack-control bundle between the op sequencer and its operand stack.
interface stack_op_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] imm;
  logic [7:0] stk_out;
  logic [7:0] stk_in;
  logic       stk_push;
  logic       stk_pop;
  logic       stk_tos;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] result;
  logic [5:0] depth;

  modport master (
    output start, op, imm, stk_out,
    input  stk_in, stk_push, stk_pop, stk_tos, busy, done, err, result, depth
  );

  modport slave (
    input  start, op, imm, stk_out,
    output stk_in, stk_push, stk_pop, stk_tos, busy, done, err, result, depth
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Stack-machine op sequencer: one op at a time, done after 1..5 cycles depending on op.
// No queueing: start is only sampled in IDLE; depth is checked before any stack line moves.
module stack_op_sequencer #(
  parameter int DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_op_sequencer_if.slave  sif
);

  typedef enum logic [2:0] {IDLE, FETCH, POP2, READ, PUSH, DONE, ERR} state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSHI = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_DUP   = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;
  localparam logic [5:0] DEPTH_MAX = 6'(DEPTH);

  state_t     state;
  logic [2:0] op_q;
  logic [7:0] imm_q;
  logic [7:0] b_q;
  logic [7:0] result_q;
  logic [7:0] stk_in_q;
  logic       push_q, pop_q, tos_q;
  logic       busy_q, done_q, err_q;
  logic [5:0] depth_q;
  logic       depth_ok;
  logic       is_binary;
  logic [7:0] alu;

  always_comb begin
    depth_ok = 1'b1;
    case (sif.op)
      OP_PUSHI:              depth_ok = (depth_q < DEPTH_MAX);
      OP_POP, OP_NOT:        depth_ok = (depth_q >= 6'd1);
      OP_DUP:                depth_ok = (depth_q >= 6'd1) && (depth_q < DEPTH_MAX);
      OP_ADD, OP_SUB, OP_AND: depth_ok = (depth_q >= 6'd2);
      default:               depth_ok = 1'b1;
    endcase
  end

  assign is_binary = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);

  // stk_out holds A (the deeper operand) in READ; B was captured in POP2.
  always_comb begin
    alu = sif.stk_out;
    case (op_q)
      OP_ADD:  alu = sif.stk_out + b_q;
      OP_SUB:  alu = sif.stk_out - b_q;
      OP_AND:  alu = sif.stk_out & b_q;
      OP_NOT:  alu = ~sif.stk_out;
      default: alu = sif.stk_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      imm_q    <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      stk_in_q <= 8'h00;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      tos_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      depth_q  <= 6'd0;
    end else begin
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      tos_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      stk_in_q <= 8'h00;

      // Depth follows the stack controls as they are presented to the stack.
      if (push_q)
        depth_q <= depth_q + 6'd1;
      else if (pop_q)
        depth_q <= depth_q - 6'd1;

      case (state)
        IDLE: begin
          if (sif.start) begin
            op_q   <= sif.op;
            imm_q  <= sif.imm;
            busy_q <= 1'b1;
            if (!depth_ok) begin
              state  <= ERR;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (sif.op == OP_NOP) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (sif.op == OP_PUSHI) begin
              state    <= PUSH;
              push_q   <= 1'b1;
              stk_in_q <= sif.imm;
            end else begin
              state <= FETCH;
              if (sif.op == OP_DUP)
                tos_q <= 1'b1;
              else
                pop_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (is_binary) begin
            state <= POP2;
            pop_q <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        POP2: begin
          b_q   <= sif.stk_out;
          state <= READ;
        end
        READ: begin
          result_q <= alu;
          if (op_q == OP_POP) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state    <= PUSH;
            push_q   <= 1'b1;
            stk_in_q <= alu;
          end
        end
        PUSH: begin
          if (op_q == OP_PUSHI)
            result_q <= imm_q;
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE, ERR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign sif.stk_in   = stk_in_q;
  assign sif.stk_push = push_q;
  assign sif.stk_pop  = pop_q;
  assign sif.stk_tos  = tos_q;
  assign sif.busy     = busy_q;
  assign sif.done     = done_q;
  assign sif.err      = err_q;
  assign sif.result   = result_q;
  assign sif.depth    = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: a behavioural 32-entry stack plus a reference stack scoreboard.
module tb_stack_op_sequencer;

  typedef struct {
    bit         err;
    logic [7:0] res;
    int         dep;
    int         lat;
    int         npush;
    int         npop;
    int         ntos;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_op_sequencer_if sif ();
  stack_op_sequencer #(.DEPTH(32)) dut (.clk(clk), .rst(rst), .sif(sif));

  logic [7:0] mem [32];
  logic [5:0] sp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp          <= 6'd0;
      sif.stk_out <= 8'h00;
    end else if (sif.stk_push) begin
      mem[sp[4:0]] <= sif.stk_in;
      sp           <= sp + 6'd1;
    end else if (sif.stk_pop) begin
      sif.stk_out <= mem[5'(sp - 6'd1)];
      sp          <= sp - 6'd1;
    end else if (sif.stk_tos) begin
      sif.stk_out <= mem[5'(sp - 6'd1)];
    end
  end

  int n_push, n_pop, n_tos, n_multi;
  always @(posedge clk) begin
    if (!rst) begin
      if (sif.stk_push === 1'b1) n_push++;
      if (sif.stk_pop === 1'b1) n_pop++;
      if (sif.stk_tos === 1'b1) n_tos++;
      if (int'(sif.stk_push) + int'(sif.stk_pop) + int'(sif.stk_tos) > 1) n_multi++;
    end
  end

  logic [7:0] ref_stk [$];
  logic [7:0] ref_result;
  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    ref_result = 8'h00;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] imm, input bit noise);
    exp_t       e;
    logic [7:0] a, b;
    int         d, lat;
    bit         seen;
    d = ref_stk.size();
    e.err = 1'b0; e.npush = 0; e.npop = 0; e.ntos = 0; e.lat = 1;
    case (op)
      3'b000: e.lat = 1;
      3'b001: begin e.err = !(d < 32); e.lat = 2; e.npush = 1; end
      3'b010: begin e.err = !(d >= 1); e.lat = 3; e.npop = 1; end
      3'b011: begin e.err = !(d >= 1 && d < 32); e.lat = 4; e.ntos = 1; e.npush = 1; end
      3'b111: begin e.err = !(d >= 1); e.lat = 4; e.npop = 1; e.npush = 1; end
      default: begin e.err = !(d >= 2); e.lat = 5; e.npop = 2; e.npush = 1; end
    endcase
    if (e.err) begin
      e.lat = 1; e.npush = 0; e.npop = 0; e.ntos = 0;
    end else begin
      case (op)
        3'b001: begin ref_result = imm; ref_stk.push_back(imm); end
        3'b010: ref_result = ref_stk.pop_back();
        3'b011: begin ref_result = ref_stk[$]; ref_stk.push_back(ref_result); end
        3'b111: begin a = ref_stk.pop_back(); ref_result = ~a; ref_stk.push_back(ref_result); end
        3'b100, 3'b101, 3'b110: begin
          b = ref_stk.pop_back();
          a = ref_stk.pop_back();
          ref_result = (op == 3'b100) ? a + b : (op == 3'b101) ? a - b : a & b;
          ref_stk.push_back(ref_result);
        end
        default: ;
      endcase
    end
    e.res = ref_result;
    e.dep = ref_stk.size();
    sb.push_back(e);

    @(negedge clk);
    vectors++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_before_op%0d: busy=%b done=%b, required 0 0", op, sif.busy, sif.done);
    end
    n_push = 0; n_pop = 0; n_tos = 0; n_multi = 0;
    sif.op = op; sif.imm = imm; sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    if (noise) begin sif.op = 3'b001; sif.imm = 8'hFF; end
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (sif.done === 1'b1) begin
        seen = 1'b1; lat = n;
      end else begin
        sif.start = noise && sif.busy && n[0];
      end
    end
    sif.start = 1'b0;
    e = sb.pop_front();

    vectors++;
    if (!seen) begin miscompares++; $display("FAIL done_timeout op%0d: no done within 20 cycles", op); end
    vectors++;
    if (lat != e.lat) begin miscompares++; $display("FAIL latency op%0d: got %0d, required %0d", op, lat, e.lat); end
    vectors++;
    if (sif.err !== e.err) begin miscompares++; $display("FAIL err op%0d: got %b, required %b", op, sif.err, e.err); end
    vectors++;
    if (sif.result !== e.res) begin miscompares++; $display("FAIL result op%0d: got %h, required %h", op, sif.result, e.res); end
    vectors++;
    if (sif.depth !== 6'(e.dep)) begin miscompares++; $display("FAIL depth op%0d: got %0d, required %0d", op, sif.depth, e.dep); end
    vectors++;
    if (n_push != e.npush || n_pop != e.npop || n_tos != e.ntos) begin
      miscompares++;
      $display("FAIL stack_ctl op%0d: push/pop/tos got %0d/%0d/%0d, required %0d/%0d/%0d",
               op, n_push, n_pop, n_tos, e.npush, e.npop, e.ntos);
    end
    vectors++;
    if (n_multi != 0) begin miscompares++; $display("FAIL ctl_onehot op%0d: %0d cycles with >1 control, required 0", op, n_multi); end
    if (e.dep > 0) begin
      vectors++;
      if (mem[5'(sp - 6'd1)] !== ref_stk[$]) begin
        miscompares++;
        $display("FAIL stack_top op%0d: got %h, required %h", op, mem[5'(sp - 6'd1)], ref_stk[$]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sif.busy, sif.done, sif.err, sif.stk_push, sif.stk_pop, sif.stk_tos} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: busy/done/err/push/pop/tos=%b, required 000000",
               {sif.busy, sif.done, sif.err, sif.stk_push, sif.stk_pop, sif.stk_tos});
    end
    vectors++;
    if (sif.depth !== 6'd0 || sif.result !== 8'h00 || sif.stk_in !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: depth=%0d result=%h stk_in=%h, required 0 00 00", sif.depth, sif.result, sif.stk_in);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    ref_result = 8'h00;
  endtask

  task automatic test_sub();
    do_reset();
    do_op(3'b001, 8'h05, 1'b0);
    do_op(3'b001, 8'h03, 1'b0);
    do_op(3'b101, 8'h00, 1'b0);
  endtask

  task automatic test_add_wrap();
    do_reset();
    do_op(3'b001, 8'hF0, 1'b0);
    do_op(3'b001, 8'h20, 1'b0);
    do_op(3'b100, 8'h00, 1'b0);
  endtask

  task automatic test_underflow();
    do_reset();
    do_op(3'b010, 8'h00, 1'b0);
    do_op(3'b001, 8'h11, 1'b0);
    do_op(3'b100, 8'h00, 1'b0);
    do_op(3'b000, 8'h00, 1'b0);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) do_op(3'b001, 8'(i * 7 + 1), 1'b0);
    do_op(3'b001, 8'hEE, 1'b0);
    do_op(3'b011, 8'h00, 1'b0);
    do_op(3'b111, 8'h00, 1'b0);
    do_op(3'b110, 8'h00, 1'b0);
  endtask

  task automatic test_dup_not();
    do_reset();
    do_op(3'b001, 8'h5A, 1'b0);
    do_op(3'b011, 8'h00, 1'b1);
    do_op(3'b111, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_op(3'b001, 8'h01, 1'b0);
    do_op(3'b001, 8'h02, 1'b0);
    @(negedge clk);
    sif.op = 3'b100; sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sif.busy !== 1'b1 || sif.stk_pop !== 1'b1) begin
      miscompares++;
      $display("FAIL in_pop2: busy=%b stk_pop=%b, required 1 1", sif.busy, sif.stk_pop);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({sif.busy, sif.done, sif.err, sif.stk_push, sif.stk_pop, sif.stk_tos} !== 6'b0) begin
      miscompares++;
      $display("FAIL midreset_ctl: busy/done/err/push/pop/tos=%b, required 000000",
               {sif.busy, sif.done, sif.err, sif.stk_push, sif.stk_pop, sif.stk_tos});
    end
    vectors++;
    if (sif.depth !== 6'd0 || sif.result !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_data: depth=%0d result=%h, required 0 00", sif.depth, sif.result);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    ref_result = 8'h00;
    do_op(3'b001, 8'h77, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 60; i++)
      do_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    sif.start = 1'b0;
    sif.op    = 3'b000;
    sif.imm   = 8'h00;
    test_reset();
    test_sub();
    test_add_wrap();
    test_underflow();
    test_full();
    test_dup_not();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

endmodule
